// File: rtl/threshold_monitor_pkg.sv
// threshold_monitor_pkg
//   Shared types and helpers for the threshold monitor.
//   - state_e   : debounce FSM states
//   - cnt_width : width of the run counter for given set/clear run lengths
package threshold_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ALARM    = 2'd2,
    ST_CLEARING = 2'd3
  } state_e;

  // The counter must hold values up to max(set_count, clr_count).
  function automatic int cnt_width(input int set_count, input int clr_count);
    int m;
    m = (set_count > clr_count) ? set_count : clr_count;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/comparator4bit.sv
// comparator4bit
//   Combinational unsigned magnitude compare of A against B.
//   Ports:
//     A, B  in  WIDTH  operands
//     AgtB  out 1      A >  B
//     AltB  out 1      A <  B
//     AeqB  out 1      A == B
//   Exactly one of the three flags is high at any time.
module comparator4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             AgtB,
  output logic             AltB,
  output logic             AeqB
);

  always_comb begin
    AgtB = (A > B);
    AltB = (A < B);
    AeqB = (A == B);
  end

endmodule

// File: rtl/threshold_monitor.sv
// threshold_monitor
//   Debounced threshold alarm. Each valid sample is compared with a
//   programmable threshold; SET_COUNT consecutive above-threshold samples
//   raise the alarm, CLR_COUNT consecutive below-threshold samples release
//   it. A sample equal to the threshold breaks an arming run and breaks a
//   clearing run (hysteresis). The largest sample seen while alarmed is
//   captured in peak.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     sample_valid  sample is consumed on this rising edge
//     sample        unsigned sample
//     thresh_load   load thresh_in into the threshold register
//     thresh_in     new threshold
//     alarm         high in ALARM and CLEARING (registered)
//     event_pulse   one-cycle pulse on entry to ALARM from IDLE/ARMING
//     clear_pulse   one-cycle pulse when the alarm releases to IDLE
//     peak          max sample of the current or most recent alarm
//     threshold     current threshold register
//     dbg_state     current FSM state (state_e encoding)
//   Handshake: there is no backpressure; a sample is taken on every rising
//   edge where sample_valid=1, and edges with sample_valid=0 leave the
//   state, run counter and peak untouched.
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               SET_COUNT  = 3,
  parameter int               CLR_COUNT  = 2,
  parameter logic [WIDTH-1:0] THRESH_RST = 4'b1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             thresh_load,
  input  logic [WIDTH-1:0] thresh_in,
  output logic             alarm,
  output logic             event_pulse,
  output logic             clear_pulse,
  output logic [WIDTH-1:0] peak,
  output logic [WIDTH-1:0] threshold,
  output logic [1:0]       dbg_state
);

  localparam int             CNT_W = cnt_width(SET_COUNT, CLR_COUNT);
  localparam logic [CNT_W-1:0] SET_C = CNT_W'(SET_COUNT);
  localparam logic [CNT_W-1:0] CLR_C = CNT_W'(CLR_COUNT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               alarm_q, alarm_d;
  logic               event_q, event_d;
  logic               clear_q, clear_d;
  logic [WIDTH-1:0]   peak_q, peak_d;
  logic [WIDTH-1:0]   thresh_q, thresh_d;

  logic gt, lt, eq;

  // Compare uses the threshold register before any same-cycle load.
  comparator4bit #(.WIDTH(WIDTH)) u_cmp (
    .A    (sample),
    .B    (thresh_q),
    .AgtB (gt),
    .AltB (lt),
    .AeqB (eq)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
      event_q  <= 1'b0;
      clear_q  <= 1'b0;
      peak_q   <= '0;
      thresh_q <= THRESH_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alarm_q  <= alarm_d;
      event_q  <= event_d;
      clear_q  <= clear_d;
      peak_q   <= peak_d;
      thresh_q <= thresh_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sample_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (gt) begin
            if (SET_COUNT == 1) begin
              state_d = ST_ALARM;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARMING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (gt) begin
            if (cnt_inc == SET_C) begin
              state_d = ST_ALARM;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else if (lt || eq) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_ALARM: begin
          if (lt) begin
            if (CLR_COUNT == 1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_CLEARING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_CLEARING: begin
          if (lt) begin
            if (cnt_inc == CLR_C) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else if (gt || eq) begin
            // Back to ALARM silently: the alarm never dropped.
            state_d = ST_ALARM;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic (registered next cycle)
  always_comb begin
    alarm_d  = (state_d == ST_ALARM) || (state_d == ST_CLEARING);
    event_d  = 1'b0;
    clear_d  = 1'b0;
    peak_d   = peak_q;
    thresh_d = thresh_load ? thresh_in : thresh_q;

    if ((state_d == ST_ALARM) &&
        ((state_q == ST_IDLE) || (state_q == ST_ARMING))) begin
      event_d = 1'b1;
      peak_d  = sample;
    end else if (alarm_q && sample_valid && (sample > peak_q)) begin
      peak_d  = sample;
    end

    // Any release of the alarm, including ALARM->IDLE when CLR_COUNT==1.
    if ((state_d == ST_IDLE) &&
        ((state_q == ST_CLEARING) || (state_q == ST_ALARM))) begin
      clear_d = 1'b1;
    end
  end

  assign alarm       = alarm_q;
  assign event_pulse = event_q;
  assign clear_pulse = clear_q;
  assign peak        = peak_q;
  assign threshold   = thresh_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_threshold_monitor.sv
module tb_threshold_monitor;

  localparam int         SET_COUNT  = 3;
  localparam int         CLR_COUNT  = 2;
  localparam logic [3:0] THRESH_RST = 4'b1000;
  localparam int         EXP_W      = 13;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [3:0] sample;
  logic       thresh_load;
  logic [3:0] thresh_in;
  logic       alarm, event_pulse, clear_pulse;
  logic [3:0] peak, threshold;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  threshold_monitor #(
    .WIDTH(4), .SET_COUNT(SET_COUNT), .CLR_COUNT(CLR_COUNT), .THRESH_RST(THRESH_RST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thresh_load  (thresh_load),
    .thresh_in    (thresh_in),
    .alarm        (alarm),
    .event_pulse  (event_pulse),
    .clear_pulse  (clear_pulse),
    .peak         (peak),
    .threshold    (threshold),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entry = {alarm, event, clear, peak[3:0], threshold[3:0], state[1:0]}
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: run-length counting, state derived from (alarm, run).
  logic       m_alarm;
  int         m_run;
  logic [3:0] m_peak;
  logic [3:0] m_thr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_alarm = 1'b0;
    m_run   = 0;
    m_peak  = 4'd0;
    m_thr   = THRESH_RST;
    exp_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [3:0] s,
                            input logic ld, input logic [3:0] ti);
    logic       ev;
    logic       cl;
    logic [1:0] st;
    ev = 1'b0;
    cl = 1'b0;
    if (v) begin
      if (!m_alarm) begin
        if (s > m_thr) begin
          m_run++;
          if (m_run == SET_COUNT) begin
            m_alarm = 1'b1;
            m_run   = 0;
            ev      = 1'b1;
            m_peak  = s;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (s > m_peak) m_peak = s;
        if (s < m_thr) begin
          m_run++;
          if (m_run == CLR_COUNT) begin
            m_alarm = 1'b0;
            m_run   = 0;
            cl      = 1'b1;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    if (ld) m_thr = ti;
    if (!m_alarm) st = (m_run == 0) ? 2'd0 : 2'd1;
    else          st = (m_run == 0) ? 2'd2 : 2'd3;
    exp_q.push_back({m_alarm, ev, cl, m_peak, m_thr, st});
  endtask

  task automatic compare_out();
    logic [EXP_W-1:0] e;
    check("sb_depth", 16'(exp_q.size()), 16'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("alarm",       16'(alarm),       16'(e[12]));
      check("event_pulse", 16'(event_pulse), 16'(e[11]));
      check("clear_pulse", 16'(clear_pulse), 16'(e[10]));
      check("peak",        16'(peak),        16'(e[9:6]));
      check("threshold",   16'(threshold),   16'(e[5:2]));
      check("state",       16'(dbg_state),   16'(e[1:0]));
      check("pulse_excl",  16'(event_pulse & clear_pulse), 16'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] s,
                       input logic ld = 1'b0, input logic [3:0] ti = 4'd0);
    @(negedge clk);
    sample_valid = v;
    sample       = s;
    thresh_load  = ld;
    thresh_in    = ti;
    model_step(v, s, ld, ti);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic gap();
    drive(1'b0, 4'd0);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    sample_valid = 1'b0;
    thresh_load  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_alarm"}, 16'(alarm), 16'd0);
    check({tag, "_event"}, 16'(event_pulse), 16'd0);
    check({tag, "_clear"}, 16'(clear_pulse), 16'd0);
    check({tag, "_peak"},  16'(peak), 16'd0);
    check({tag, "_thr"},   16'(threshold), 16'(THRESH_RST));
    check({tag, "_state"}, 16'(dbg_state), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = 4'd0;
    thresh_load  = 1'b0;
    thresh_in    = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Raise
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1010);
    drive(1'b1, 4'b1100);
    check("raise_alarm", 16'(alarm), 16'd1);
    check("raise_event", 16'(event_pulse), 16'd1);
    check("raise_peak",  16'(peak), 16'b1100);
    gap();
    check("event_one_cycle", 16'(event_pulse), 16'd0);

    // Hysteresis and clear
    drive(1'b1, 4'b1000);
    drive(1'b1, 4'b0111);
    drive(1'b1, 4'b1111);
    check("hyst_peak",  16'(peak), 16'b1111);
    check("hyst_alarm", 16'(alarm), 16'd1);
    drive(1'b1, 4'b0111);
    drive(1'b1, 4'b0001);
    check("clear_pulse_hi", 16'(clear_pulse), 16'd1);
    check("clear_alarm",    16'(alarm), 16'd0);
    gap();
    check("clear_one_cycle", 16'(clear_pulse), 16'd0);
    check("peak_hold",       16'(peak), 16'b1111);

    // Broken run: the eq sample returns to IDLE
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1000);
    check("broken_idle", 16'(dbg_state), 16'd0);
    drive(1'b1, 4'b1001);
    check("broken_alarm", 16'(alarm), 16'd0);

    // Valid gaps and same-cycle threshold load
    drive(1'b1, 4'b1001);
    gap();
    drive(1'b1, 4'b1001, 1'b1, 4'b1111);
    check("load_alarm", 16'(alarm), 16'd1);
    check("load_thr",   16'(threshold), 16'b1111);
    drive(1'b1, 4'b1010);
    check("load_clearing", 16'(dbg_state), 16'd3);
    drive(1'b1, 4'b0000);

    // Reset mid-ARMING
    pulse_reset("rst_a");
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1001);
    pulse_reset("rst_b");
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1001);
    check("rst_no_alarm", 16'(alarm), 16'd0);
    drive(1'b1, 4'b1001);
    check("rst_third_alarm", 16'(alarm), 16'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 11) == 0),
            4'($urandom_range(2, 13)));
    end

    pulse_reset("rst_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/threshold_monitor.md
# threshold_monitor

Sequential consumer of 4-bit magnitude-compare results. Compares each valid sample against a programmable threshold using the existing `comparator4bit` block. Asserts a debounced `alarm` after a run of consecutive samples above threshold. Releases it after a run of consecutive samples below threshold, with equality acting as hysteresis. Sits directly downstream of `comparator4bit` and turns its per-sample AgtB/AltB/AeqB flags into a stable alarm with event pulses and a peak capture.

## Interface
- WIDTH, 4: sample and threshold width.
- SET_COUNT, 3: consecutive above-threshold samples needed to raise the alarm (≥1).
- CLR_COUNT, 2: consecutive below-threshold samples needed to release the alarm (≥1).
- THRESH_RST, 4'b1000: threshold register value after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  the sample is consumed on this clock edge.
- sample  in  WIDTH  unsigned sample.
- thresh_load  in  1  load `thresh_in` into the threshold register.
- thresh_in  in  WIDTH  new unsigned threshold.
- alarm  out  1  high in states ALARM and CLEARING.
- event_pulse  out  1  one-cycle pulse on entry to ALARM.
- clear_pulse  out  1  one-cycle pulse on return from CLEARING to IDLE.
- peak  out  WIDTH  maximum sample seen during the current or most recent alarm.
- threshold  out  WIDTH  current threshold register value.

## Operation
- Compare is combinational: `sample` vs. the threshold register, done by the `comparator4bit` instance. gt, lt and eq are one-hot.
- FSM states: IDLE, ARMING, ALARM, CLEARING. A run counter `cnt` is sized for max(SET_COUNT, CLR_COUNT).
- Cycles without `sample_valid` hold the state, `cnt` and `peak` unchanged.
- IDLE:
  - valid&gt: go to ALARM if SET_COUNT==1, otherwise to ARMING with cnt=1.
  - All other inputs: stay in IDLE.
- ARMING:
  - valid&gt: cnt+1. When cnt+1==SET_COUNT, go to ALARM with cnt=0.
  - valid&!gt (lt or eq): go to IDLE with cnt=0.
- ALARM:
  - valid&lt: go to IDLE if CLR_COUNT==1, otherwise to CLEARING with cnt=1.
  - valid&(gt|eq): stay in ALARM.
- CLEARING:
  - valid&lt: cnt+1. When cnt+1==CLR_COUNT, go to IDLE with cnt=0.
  - valid&!lt: go back to ALARM with cnt=0. No event_pulse is generated.
- peak:
  - On the sample that causes entry to ALARM from IDLE or ARMING, peak loads that sample.
  - While alarm=1 and valid, peak updates to the sample when the sample is greater than peak.
  - peak holds after the alarm clears until the next event.
- Threshold:
  - When thresh_load=1, the register takes thresh_in at the edge.
  - A sample presented in the same cycle is compared against the old threshold.
  - A threshold change never resets the FSM.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - alarm=0, event_pulse=0, clear_pulse=0.
  - peak=0.
  - threshold=THRESH_RST.
- All outputs are registered. alarm, event_pulse and peak update one edge after the qualifying valid sample.
- Worst-case latency from the first above-threshold sample to alarm=1 is SET_COUNT valid samples. Gaps in valid stretch this without breaking the run.
- event_pulse and clear_pulse are high for exactly one cycle. They cannot both be high in the same cycle.
- Asserting rst mid-run (ARMING or CLEARING) immediately forces the reset values. The next run restarts from cnt=0.
- The comparator input at sample=threshold is eq. It never advances ARMING or CLEARING.

## Structure
- Package `threshold_monitor_pkg`:
  - state enum (IDLE, ARMING, ALARM, CLEARING);
  - localparam function computing the `cnt` width.
- Sub-module: one `comparator4bit` instance, with A=sample and B=threshold. For WIDTH≠4, the comparator is a generic-width equivalent with the same port names.

## Test plan
- Reset: rst=1 mid-simulation → alarm=0, peak=0000, threshold=1000 immediately (asynchronous), without waiting for clk.
- Raise: threshold=1000, valid samples 1001, 1010, 1100 → alarm=1 and event_pulse=1 one cycle after the third sample; peak=1100.
- Broken run: samples 1001, 1001, 1000, 1001 → alarm stays 0. The eq sample returns the FSM to IDLE.
- Hysteresis/clear: from alarm, samples 1000, 0111, 1111, 0111, 0001 → alarm stays 1 and peak=1111 after the 1111 sample; clear_pulse=1 one cycle after 0001, then alarm=0.
- Valid gaps and threshold load: samples 1001, gap, 1001, with thresh_load=1, thresh_in=1111 on the third sample 1001 → that sample still counts against 1000, so alarm=1; the following sample 1010 is lt and moves the FSM to CLEARING.
- Reset mid-ARMING: two gt samples, rst pulse, then two gt samples → no alarm; a third gt sample is required.
